// File: rtl/lock_pkg.sv
// Shared constants and state type for the combination-lock supervisor.
package lock_pkg;

  localparam logic [3:0] LED_IDLE = 4'b1111;
  localparam logic [3:0] LED_OPEN = 4'b0000;
  localparam logic [3:0] LED_ERR  = 4'b0101;
  localparam logic [3:0] KEY_CLR  = 4'b1000;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    UNLOCKED = 2'd1,
    CLEAR    = 2'd2,
    LOCKOUT  = 2'd3
  } sup_state_t;

endpackage

// File: rtl/lock_supervisor_if.sv
// Key/LED/status bundle between the user-side key source, the lock and the supervisor.
interface lock_supervisor_if;
  import lock_pkg::*;

  logic [3:0] key_in;
  logic [3:0] lock_led;
  logic [3:0] key_out;
  logic       alarm;
  logic       unlocked;
  logic [3:0] fail_cnt;

  modport master (
    output key_in, lock_led,
    input  key_out, alarm, unlocked, fail_cnt
  );

  modport slave (
    input  key_in, lock_led,
    output key_out, alarm, unlocked, fail_cnt
  );

endinterface

// File: rtl/lock_supervisor_timer.sv
// 32-bit up-counter with synchronous clear, enable and terminal-count compare.
module sup_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] tc,
  output logic        done
);
  import lock_pkg::*;

  logic [31:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

  assign done = en && (count == tc);

endmodule

// File: rtl/lock_supervisor.sv
// Supervisor between user keys and the lock: forwards keys, auto-clears errors,
// locks out after repeated failures and auto-relocks an open lock.
module lock_supervisor #(
  parameter int unsigned RELOCK_CYCLES  = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned CLR_RETRY      = 8
) (
  input  logic               clk,
  input  logic               rstn,
  lock_supervisor_if.slave   bus
);
  import lock_pkg::*;

  localparam logic [3:0]  FAIL_MAX   = 4'(MAX_FAILS);
  localparam logic [31:0] RELOCK_TC  = 32'(RELOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_TC = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [31:0] CLR_TC     = 32'(CLR_RETRY - 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= FAIL_MAX) ? FAIL_MAX : v + 4'd1;
  endfunction

  sup_state_t  state, state_nx;
  logic [3:0]  key_nx;
  logic [3:0]  fail_nx;
  logic        tmr_clr;
  logic        tmr_en;
  logic [31:0] tmr_tc;
  logic        tmr_done;

  // Timer enable and compare value depend only on the current state, so the
  // done flag never loops back through the next-state logic.
  assign tmr_en = (state != ARMED);
  assign tmr_tc = (state == UNLOCKED) ? RELOCK_TC :
                  (state == LOCKOUT)  ? LOCKOUT_TC : CLR_TC;

  sup_timer u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc),
    .done (tmr_done)
  );

  always_comb begin
    state_nx = state;
    key_nx   = 4'b0000;
    fail_nx  = bus.fail_cnt;
    tmr_clr  = 1'b0;
    case (state)
      ARMED: begin
        key_nx = bus.key_in;
        if (bus.lock_led == LED_ERR) begin
          fail_nx = sat_inc(bus.fail_cnt);
          key_nx  = 4'b0000;
          if (fail_nx == FAIL_MAX) begin
            state_nx = LOCKOUT;
          end else begin
            key_nx   = KEY_CLR;
            state_nx = CLEAR;
          end
        end else if (bus.lock_led == LED_OPEN) begin
          fail_nx  = 4'd0;
          state_nx = UNLOCKED;
        end
      end
      UNLOCKED: begin
        key_nx = bus.key_in;
        if (bus.lock_led == LED_IDLE) begin
          state_nx = ARMED;
        end else if (tmr_done) begin
          // OR-ing keeps a coincident user key 3 to a single pulse.
          key_nx   = bus.key_in | KEY_CLR;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (bus.lock_led == LED_IDLE) begin
          state_nx = ARMED;
        end else if (tmr_done) begin
          key_nx  = KEY_CLR;
          tmr_clr = 1'b1;
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          fail_nx  = 4'd0;
          key_nx   = KEY_CLR;
          state_nx = CLEAR;
        end
      end
      default: state_nx = ARMED;
    endcase
    if (state_nx != state) tmr_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ARMED;
      bus.key_out  <= 4'b0000;
      bus.fail_cnt <= 4'd0;
      bus.alarm    <= 1'b0;
      bus.unlocked <= 1'b0;
    end else begin
      state        <= state_nx;
      bus.key_out  <= key_nx;
      bus.fail_cnt <= fail_nx;
      bus.alarm    <= (state_nx == LOCKOUT);
      bus.unlocked <= (state_nx == UNLOCKED);
    end
  end

endmodule
